accelerator_vector_integer_mac: RTL and testbench

ACCELERATOR_VECTOR_INTEGER_MAC -- requirements
Module: accelerator_vector_integer_mac

---
 rtl/accelerator_vector_integer_mac_pkg.sv | 23 ++
 rtl/accelerator_vector_integer_mac_if.sv | 30 +++
 rtl/accelerator_integer_multiplier_core.sv | 33 +++
 rtl/accelerator_vector_integer_mac.sv | 166 ++++++++++++++++
 tb/tb_accelerator_vector_integer_mac.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/accelerator_vector_integer_mac_pkg.sv
// Shared types and constants for the vector integer multiply-accumulate block.
package accelerator_vector_integer_mac_pkg;

    // Controller states. Every 2-bit code is named, but the controller still
    // falls back to STARTER on anything unexpected.
    typedef enum logic [1:0] {
        STARTER  = 2'b00,
        INPUT    = 2'b01,
        MULTIPLY = 2'b10,
        ENDER    = 2'b11
    } state_t;

    // Operation selected by MODE_IN when START is sampled.
    localparam logic MODE_ELEMENTWISE = 1'b0;
    localparam logic MODE_DOT         = 1'b1;

    // Wide constants, resized to the instance widths where they are used.
    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;
    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;

endpackage

// File: rtl/accelerator_vector_integer_mac_if.sv
// Operand/result bus of the vector integer MAC. The master drives commands and
// operands; the slave (the MAC) returns results and status.
interface accelerator_vector_integer_mac_if #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64
) ();

    logic                    START;
    logic                    READY;
    logic                    MODE_IN;
    logic [CONTROL_SIZE-1:0] SIZE_IN;
    logic                    DATA_A_IN_ENABLE;
    logic                    DATA_B_IN_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_A_IN;
    logic [DATA_SIZE-1:0]    DATA_B_IN;
    logic                    DATA_OUT_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_OUT;
    logic                    OVERFLOW_OUT;

    modport master (
        output START, MODE_IN, SIZE_IN, DATA_A_IN_ENABLE, DATA_B_IN_ENABLE, DATA_A_IN, DATA_B_IN,
        input  READY, DATA_OUT_ENABLE, DATA_OUT, OVERFLOW_OUT
    );

    modport slave (
        input  START, MODE_IN, SIZE_IN, DATA_A_IN_ENABLE, DATA_B_IN_ENABLE, DATA_A_IN, DATA_B_IN,
        output READY, DATA_OUT_ENABLE, DATA_OUT, OVERFLOW_OUT
    );

endinterface

// File: rtl/accelerator_integer_multiplier_core.sv
// Registered unsigned multiplier: full double-width product plus a flag for any
// bit set above the low DATA_SIZE bits, both captured in one cycle.
module accelerator_integer_multiplier_core #(
    parameter int unsigned DATA_SIZE = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENABLE,
    input  logic [DATA_SIZE-1:0]     DATA_A_IN,
    input  logic [DATA_SIZE-1:0]     DATA_B_IN,
    output logic [2*DATA_SIZE-1:0]   PRODUCT_OUT,
    output logic                     OVERFLOW_OUT
);

    logic [2*DATA_SIZE-1:0] full_product;

    // Zero-extend before multiplying so no high bits are lost.
    always_comb begin
        full_product = {{DATA_SIZE{1'b0}}, DATA_A_IN} * {{DATA_SIZE{1'b0}}, DATA_B_IN};
    end

    // Capture product and its overflow bit when the controller requests it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PRODUCT_OUT  <= '0;
            OVERFLOW_OUT <= 1'b0;
        end else if (ENABLE) begin
            PRODUCT_OUT  <= full_product;
            OVERFLOW_OUT <= |full_product[2*DATA_SIZE-1:DATA_SIZE];
        end
    end

endmodule

// File: rtl/accelerator_vector_integer_mac.sv
// Vector integer MAC: elementwise product (mode 0) or dot product (mode 1) of
// two operand streams, one element pair at a time.
// Build option: define ACCELERATOR_VECTOR_INTEGER_MAC_SATURATE_EN to clamp
// overflowing products and sums to all-ones instead of wrapping.
module accelerator_vector_integer_mac
    import accelerator_vector_integer_mac_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64
) (
    input logic                              CLK,
    input logic                              RST,
    accelerator_vector_integer_mac_if.slave  bus
);

    localparam logic [CONTROL_SIZE-1:0] ZERO_C = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] ONE_C  = CONTROL_SIZE'(ONE_CONTROL);
    localparam logic [DATA_SIZE-1:0]    ZERO_D = DATA_SIZE'(ZERO_DATA);

    state_t                  state_q;
    logic                    mode_q;
    logic [CONTROL_SIZE-1:0] size_q;
    logic [CONTROL_SIZE-1:0] index_q;
    logic [DATA_SIZE-1:0]    acc_q;
    logic [DATA_SIZE-1:0]    a_q;
    logic [DATA_SIZE-1:0]    b_q;
    logic                    flag_a_q;
    logic                    flag_b_q;
    logic                    ready_q;
    logic                    data_out_enable_q;
    logic [DATA_SIZE-1:0]    data_out_q;
    logic                    overflow_q;

    logic                    multiply_enable;
    logic [2*DATA_SIZE-1:0]  product;
    logic                    product_overflow;
    logic [DATA_SIZE-1:0]    element_result;
    logic [DATA_SIZE:0]      sum_wide;
    logic                    acc_carry;
    logic [DATA_SIZE-1:0]    acc_next;
    logic                    last_element;

    assign multiply_enable = (state_q == MULTIPLY);

    accelerator_integer_multiplier_core #(
        .DATA_SIZE (DATA_SIZE)
    ) u_multiplier (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (multiply_enable),
        .DATA_A_IN    (a_q),
        .DATA_B_IN    (b_q),
        .PRODUCT_OUT  (product),
        .OVERFLOW_OUT (product_overflow)
    );

    // Element result, accumulator update and last-element detection.
    always_comb begin
`ifdef ACCELERATOR_VECTOR_INTEGER_MAC_SATURATE_EN
        element_result = product_overflow ? '1 : product[DATA_SIZE-1:0];
`else
        element_result = product[DATA_SIZE-1:0];
`endif
        sum_wide  = {1'b0, acc_q} + {1'b0, element_result};
        acc_carry = sum_wide[DATA_SIZE];
`ifdef ACCELERATOR_VECTOR_INTEGER_MAC_SATURATE_EN
        // Once clamped, the accumulator stays at all-ones: any further nonzero
        // addend carries out again.
        acc_next = acc_carry ? '1 : sum_wide[DATA_SIZE-1:0];
`else
        acc_next = sum_wide[DATA_SIZE-1:0];
`endif
        last_element = (index_q == size_q - ONE_C);
    end

    // Controller with registered outputs; pulses default low every cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= STARTER;
            mode_q            <= MODE_ELEMENTWISE;
            size_q            <= ZERO_C;
            index_q           <= ZERO_C;
            acc_q             <= ZERO_D;
            a_q               <= ZERO_D;
            b_q               <= ZERO_D;
            flag_a_q          <= 1'b0;
            flag_b_q          <= 1'b0;
            ready_q           <= 1'b0;
            data_out_enable_q <= 1'b0;
            data_out_q        <= ZERO_D;
            overflow_q        <= 1'b0;
        end else begin
            ready_q           <= 1'b0;
            data_out_enable_q <= 1'b0;
            case (state_q)
                STARTER: begin
                    if (bus.START) begin
                        size_q     <= bus.SIZE_IN;
                        mode_q     <= bus.MODE_IN;
                        index_q    <= ZERO_C;
                        acc_q      <= ZERO_D;
                        overflow_q <= 1'b0;
                        // An empty vector skips straight to completion.
                        state_q    <= (bus.SIZE_IN == ZERO_C) ? ENDER : INPUT;
                    end
                end
                INPUT: begin
                    if (flag_a_q && flag_b_q) begin
                        state_q <= MULTIPLY;
                    end else begin
                        if (bus.DATA_A_IN_ENABLE) begin
                            a_q      <= bus.DATA_A_IN;
                            flag_a_q <= 1'b1;
                        end
                        if (bus.DATA_B_IN_ENABLE) begin
                            b_q      <= bus.DATA_B_IN;
                            flag_b_q <= 1'b1;
                        end
                    end
                end
                MULTIPLY: begin
                    flag_a_q <= 1'b0;
                    flag_b_q <= 1'b0;
                    state_q  <= ENDER;
                end
                ENDER: begin
                    if (size_q == ZERO_C) begin
                        ready_q <= 1'b1;
                        state_q <= STARTER;
                        if (mode_q == MODE_DOT) begin
                            data_out_q        <= ZERO_D;
                            data_out_enable_q <= 1'b1;
                        end
                    end else begin
                        if (mode_q == MODE_ELEMENTWISE) begin
                            data_out_q        <= element_result;
                            data_out_enable_q <= 1'b1;
                            overflow_q        <= overflow_q | product_overflow;
                        end else begin
                            acc_q      <= acc_next;
                            overflow_q <= overflow_q | product_overflow | acc_carry;
                            if (last_element) begin
                                data_out_q        <= acc_next;
                                data_out_enable_q <= 1'b1;
                            end
                        end
                        if (last_element) begin
                            ready_q <= 1'b1;
                            state_q <= STARTER;
                        end else begin
                            index_q <= index_q + ONE_C;
                            state_q <= INPUT;
                        end
                    end
                end
                default: state_q <= STARTER;
            endcase
        end
    end

    assign bus.READY           = ready_q;
    assign bus.DATA_OUT_ENABLE = data_out_enable_q;
    assign bus.DATA_OUT        = data_out_q;
    assign bus.OVERFLOW_OUT    = overflow_q;

endmodule

// File: tb/tb_accelerator_vector_integer_mac.sv
// Self-checking bench for accelerator_vector_integer_mac at DATA_SIZE=8.
// Honours ACCELERATOR_VECTOR_INTEGER_MAC_SATURATE_EN for expected results.
module tb_accelerator_vector_integer_mac;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
`ifdef ACCELERATOR_VECTOR_INTEGER_MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [DW-1:0] vec_t [8];
    typedef struct {
        logic          mode;
        int            size;
        vec_t          a;
        vec_t          b;
        vec_t          exp;
        logic          ovf;
        int            style;
        logic [DW-1:0] dup;
    } vector_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    accelerator_vector_integer_mac_if #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) bus ();

    accelerator_vector_integer_mac #(
        .DATA_SIZE    (DW),
        .CONTROL_SIZE (CW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int doe_count = 0;
    int ready_count = 0;

    // Count output pulses away from the active edge.
    always @(negedge CLK) begin
        if (bus.DATA_OUT_ENABLE === 1'b1) doe_count <= doe_count + 1;
        if (bus.READY === 1'b1) ready_count <= ready_count + 1;
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // Reference: products as plain integers; a dot-product carry happens iff the
    // running sum of low products ever reaches 256, i.e. iff the total does.
    function automatic void model(input logic mode, input int size, input vec_t a, input vec_t b,
                                  output vec_t exp, output logic ovf);
        int  p;
        int  sum_low = 0;
        bit  any_pov = 0;
        for (int i = 0; i < 8; i++) exp[i] = '0;
        for (int i = 0; i < size; i++) begin
            p = int'(a[i]) * int'(b[i]);
            if (p > 255) any_pov = 1;
            exp[i] = (SAT && p > 255) ? 8'd255 : DW'(p % 256);
            sum_low += p % 256;
        end
        ovf = any_pov || (mode && sum_low > 255);
        if (mode) exp[0] = (SAT && ovf) ? 8'd255 : DW'(sum_low % 256);
    endfunction

    // Deliver one operand pair; returns just after the edge sampling the last operand.
    task automatic drive_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int style,
                              input logic [DW-1:0] dup);
        // Stray START mid-vector must be ignored.
        bus.START   = (style == 3) || ($urandom_range(0, 3) == 0);
        bus.SIZE_IN = CW'($urandom);
        bus.MODE_IN = 1'($urandom);
        case (style)
            0: begin
                bus.DATA_A_IN = a; bus.DATA_B_IN = b;
                bus.DATA_A_IN_ENABLE = 1'b1; bus.DATA_B_IN_ENABLE = 1'b1;
                tick();
            end
            1: begin
                bus.DATA_A_IN = a; bus.DATA_A_IN_ENABLE = 1'b1; tick();
                bus.DATA_A_IN_ENABLE = 1'b0; gap();
                bus.DATA_B_IN = b; bus.DATA_B_IN_ENABLE = 1'b1; tick();
            end
            2: begin
                bus.DATA_B_IN = b; bus.DATA_B_IN_ENABLE = 1'b1; tick();
                bus.DATA_B_IN_ENABLE = 1'b0; gap();
                bus.DATA_A_IN = a; bus.DATA_A_IN_ENABLE = 1'b1; tick();
            end
            default: begin
                bus.DATA_A_IN = dup; bus.DATA_A_IN_ENABLE = 1'b1; tick();
                bus.DATA_A_IN = a; tick();
                bus.DATA_A_IN_ENABLE = 1'b0;
                bus.DATA_B_IN = b; bus.DATA_B_IN_ENABLE = 1'b1; tick();
            end
        endcase
        bus.DATA_A_IN_ENABLE = 1'b0;
        bus.DATA_B_IN_ENABLE = 1'b0;
        bus.START = 1'b0;
    endtask

    task automatic run_vector(input string name, input logic mode, input int size, input vec_t a,
                              input vec_t b, input vec_t exp, input logic exp_ovf, input int style,
                              input logic [DW-1:0] dup);
        int  doe0, rdy0, st;
        bit  last;
        bus.START = 1'b1; bus.MODE_IN = mode; bus.SIZE_IN = CW'(size);
        tick();
        bus.START = 1'b0;
        doe0 = doe_count;
        rdy0 = ready_count;
        check({name, ".ovf_cleared"}, 64'(bus.OVERFLOW_OUT), 64'(0));
        if (size == 0) begin
            tick();
            check({name, ".ready"}, 64'(bus.READY), 64'(1));
            check({name, ".doe"}, 64'(bus.DATA_OUT_ENABLE), 64'(mode));
            if (mode) check({name, ".data"}, 64'(bus.DATA_OUT), 64'(exp[0]));
        end else begin
            for (int e = 0; e < size; e++) begin
                last = (e == size - 1);
                st = (style == 4) ? int'($urandom_range(0, 3)) : style;
                drive_pair(a[e], b[e], st, dup);
                tick();
                // Operands offered while multiplying/ending must be ignored.
                bus.DATA_A_IN = DW'($urandom); bus.DATA_B_IN = DW'($urandom);
                bus.DATA_A_IN_ENABLE = 1'b1; bus.DATA_B_IN_ENABLE = 1'b1;
                tick();
                tick();
                bus.DATA_A_IN_ENABLE = 1'b0; bus.DATA_B_IN_ENABLE = 1'b0;
                check({name, ".doe"}, 64'(bus.DATA_OUT_ENABLE), 64'(!mode || last));
                if (!mode || last)
                    check({name, ".data"}, 64'(bus.DATA_OUT), 64'(mode ? exp[0] : exp[e]));
                check({name, ".ready"}, 64'(bus.READY), 64'(last));
                if (last) check({name, ".ovf"}, 64'(bus.OVERFLOW_OUT), 64'(exp_ovf));
            end
        end
        repeat (2) tick();
        check({name, ".doe_pulses"}, 64'(doe_count - doe0), 64'(mode ? 1 : size));
        check({name, ".ready_pulses"}, 64'(ready_count - rdy0), 64'(1));
    endtask

    vector_t tbl [7];

    initial begin
        int doe0, rdy0;
        vec_t z, ra, rb, rexp;
        logic rmode, rovf;
        int rsize;
        bit wide;

        for (int i = 0; i < 8; i++) z[i] = '0;
        foreach (tbl[i]) begin
            tbl[i].a = z; tbl[i].b = z; tbl[i].exp = z; tbl[i].dup = '0;
        end
        tbl[0].mode = 1'b0; tbl[0].size = 3; tbl[0].style = 0; tbl[0].ovf = 1'b0;
        tbl[0].a = '{8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[0].b = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[0].exp = '{8'd10, 8'd18, 8'd28, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[1] = tbl[0];
        tbl[1].mode = 1'b1; tbl[1].style = 1;
        tbl[1].exp = '{8'd56, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[2].mode = 1'b0; tbl[2].size = 1; tbl[2].style = 2; tbl[2].ovf = 1'b1;
        tbl[2].a[0] = 8'd16; tbl[2].b[0] = 8'd17; tbl[2].exp[0] = SAT ? 8'd255 : 8'd16;
        tbl[3].mode = 1'b1; tbl[3].size = 2; tbl[3].style = 0; tbl[3].ovf = 1'b1;
        tbl[3].a[0] = 8'd15; tbl[3].b[0] = 8'd15; tbl[3].a[1] = 8'd10; tbl[3].b[1] = 8'd4;
        tbl[3].exp[0] = SAT ? 8'd255 : 8'd9;
        tbl[4].mode = 1'b0; tbl[4].size = 1; tbl[4].style = 3; tbl[4].ovf = 1'b0;
        tbl[4].dup = 8'd3; tbl[4].a[0] = 8'd9; tbl[4].b[0] = 8'd2; tbl[4].exp[0] = 8'd18;
        tbl[5].mode = 1'b1; tbl[5].size = 0; tbl[5].style = 0; tbl[5].ovf = 1'b0;
        tbl[6].mode = 1'b0; tbl[6].size = 0; tbl[6].style = 0; tbl[6].ovf = 1'b0;

        bus.START = 1'b0; bus.MODE_IN = 1'b0; bus.SIZE_IN = '0;
        bus.DATA_A_IN_ENABLE = 1'b0; bus.DATA_B_IN_ENABLE = 1'b0;
        bus.DATA_A_IN = '0; bus.DATA_B_IN = '0;
        repeat (2) tick();
        check("reset.ready", 64'(bus.READY), 64'(0));
        check("reset.doe", 64'(bus.DATA_OUT_ENABLE), 64'(0));
        check("reset.data", 64'(bus.DATA_OUT), 64'(0));
        check("reset.ovf", 64'(bus.OVERFLOW_OUT), 64'(0));
        RST = 1'b0;
        tick();

        foreach (tbl[i])
            run_vector($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].size, tbl[i].a, tbl[i].b,
                       tbl[i].exp, tbl[i].ovf, tbl[i].style, tbl[i].dup);

        // Reset mid-vector: first element out, second half-delivered, then RST.
        bus.START = 1'b1; bus.MODE_IN = 1'b0; bus.SIZE_IN = CW'(4);
        tick();
        bus.START = 1'b0;
        drive_pair(8'd16, 8'd17, 0, 8'd0);
        repeat (3) tick();
        check("rst.first_data", 64'(bus.DATA_OUT), 64'(SAT ? 255 : 16));
        check("rst.first_ovf", 64'(bus.OVERFLOW_OUT), 64'(1));
        bus.DATA_A_IN = 8'd5; bus.DATA_A_IN_ENABLE = 1'b1;
        tick();
        bus.DATA_A_IN_ENABLE = 1'b0;
        RST = 1'b1;
        #1;
        check("rst.ready", 64'(bus.READY), 64'(0));
        check("rst.doe", 64'(bus.DATA_OUT_ENABLE), 64'(0));
        check("rst.data", 64'(bus.DATA_OUT), 64'(0));
        check("rst.ovf", 64'(bus.OVERFLOW_OUT), 64'(0));
        tick();
        RST = 1'b0;
        doe0 = doe_count;
        rdy0 = ready_count;
        bus.DATA_B_IN = 8'd6; bus.DATA_B_IN_ENABLE = 1'b1;
        tick();
        bus.DATA_A_IN_ENABLE = 1'b1;
        tick();
        bus.DATA_A_IN_ENABLE = 1'b0; bus.DATA_B_IN_ENABLE = 1'b0;
        repeat (8) tick();
        check("rst.no_doe", 64'(doe_count - doe0), 64'(0));
        check("rst.no_ready", 64'(ready_count - rdy0), 64'(0));
        check("rst.data_held", 64'(bus.DATA_OUT), 64'(0));
        run_vector("rst.size0", 1'b1, 0, z, z, z, 1'b0, 0, 8'd0);

        // Randomized vectors against the reference model.
        for (int v = 0; v < 24; v++) begin
            rmode = 1'($urandom);
            rsize = int'($urandom_range(0, 6));
            wide  = 1'($urandom);
            ra = z; rb = z;
            for (int i = 0; i < rsize; i++) begin
                ra[i] = wide ? DW'($urandom) : DW'($urandom_range(0, 15));
                rb[i] = wide ? DW'($urandom) : DW'($urandom_range(0, 15));
            end
            model(rmode, rsize, ra, rb, rexp, rovf);
            run_vector($sformatf("rand%0d", v), rmode, rsize, ra, rb, rexp, rovf, 4,
                       DW'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
